// File: rtl/tt_um_jimktrains_vslc_mtimer.sv
// Multi-mode VSLC timer: astable, on-delay, off-delay and pulse modes
// with a tick prescaler. q/enabled/done feed back into the logic engine.
module tt_um_jimktrains_vslc_mtimer #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIDTH-1:0]   period_a,
  input  logic [WIDTH-1:0]   period_b,
  input  logic               trig,
  input  logic               clear,
  output logic               q,
  output logic               enabled,
  output logic [WIDTH-1:0]   count,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE, RUN_A, RUN_B, HOLD
  } state_t;

  typedef enum logic [1:0] {
    M_AST, M_TON, M_TOF, M_TP
  } mode_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [1:0]         r_mode;
  logic [1:0]         w_mode_n;
  logic [1:0]         w_md;
  logic               r_q;
  logic               w_q_n;
  logic               r_done;
  logic               w_done_n;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   w_count_n;
  logic [WIDTH-1:0]   r_per;
  logic [WIDTH-1:0]   w_per_n;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_presc_n;
  logic               r_trig_prev;
  logic               r_clear_prev;

  logic               w_trig_rise;
  logic               w_clr_rise;
  logic               w_run;
  logic               w_tick;
  logic               w_last;
  logic [WIDTH:0]     w_cnt_x;
  logic               w_pa_z;
  logic               w_pb_z;
  logic               w_st_a;
  logic               w_st_b;
  logic               w_go_idle;
  logic               w_go_hold;
  logic               w_ast_a;

  assign w_trig_rise = trig & ~r_trig_prev;
  assign w_clr_rise  = clear & ~r_clear_prev;
  assign w_run  = (r_state == RUN_A) ||
                  (r_state == RUN_B);
  assign w_tick = w_run &&
                  (r_presc == prescale);
  assign w_cnt_x = {1'b0, r_count} +
                   {{WIDTH{1'b0}}, 1'b1};
  // A latched period of 0 never matches, so such an interval never ends here
  assign w_last = w_tick &&
                  (w_cnt_x == {1'b0, r_per});
  assign w_pa_z = (period_a == '0);
  assign w_pb_z = (period_b == '0);
  // After an A phase: skip an empty B phase unless A is empty as well
  assign w_ast_a = w_pb_z & ~w_pa_z;

  always_comb begin
    w_state_n = r_state;
    w_mode_n  = r_mode;
    w_q_n     = r_q;
    w_done_n  = 1'b0;
    w_count_n = r_count;
    w_presc_n = r_presc;
    w_per_n   = r_per;
    w_st_a    = 1'b0;
    w_st_b    = 1'b0;
    w_go_idle = 1'b0;
    w_go_hold = 1'b0;
    w_md      = (r_state == IDLE) ? mode : r_mode;
    if (r_state == IDLE) w_mode_n = mode;
    if (w_run) begin
      w_presc_n = w_tick ? '0 :
                  r_presc + PRESC_W'(1);
      if (w_tick) w_count_n = r_count + WIDTH'(1);
    end
    if (w_clr_rise) begin
      w_go_idle = 1'b1;
      w_q_n     = 1'b0;
    end else begin
      unique case (1'b1)
        (w_md == M_AST): begin
          if ((r_state == IDLE && w_trig_rise) ||
              (r_state == RUN_B && w_last)) begin
            w_done_n = (r_state == RUN_B) | w_pa_z;
            w_st_a   = ~w_pa_z;
            w_st_b   = w_pa_z;
            w_q_n    = ~w_pa_z;
          end else if (r_state == RUN_A && w_last) begin
            w_done_n = 1'b1;
            w_st_a   = w_ast_a;
            w_st_b   = ~w_ast_a;
            w_q_n    = w_ast_a;
          end
        end
        (w_md == M_TON): begin
          if (!trig) begin
            w_go_idle = 1'b1;
            w_q_n     = 1'b0;
          end else if (r_state == IDLE) begin
            w_go_hold = w_pa_z;
            w_st_a    = ~w_pa_z;
            w_q_n     = w_pa_z;
            w_done_n  = w_pa_z;
          end else if (r_state == RUN_A && w_last) begin
            w_go_hold = 1'b1;
            w_q_n     = 1'b1;
            w_done_n  = 1'b1;
          end
        end
        (w_md == M_TOF): begin
          if (trig) begin
            w_go_hold = 1'b1;
            w_q_n     = 1'b1;
          end else if (r_state == HOLD) begin
            w_go_idle = w_pa_z;
            w_st_a    = ~w_pa_z;
            w_q_n     = ~w_pa_z;
            w_done_n  = w_pa_z;
          end else if (r_state == RUN_A && w_last) begin
            w_go_idle = 1'b1;
            w_q_n     = 1'b0;
            w_done_n  = 1'b1;
          end
        end
        (w_md == M_TP): begin
          if (r_state == IDLE && w_trig_rise) begin
            w_st_a   = ~w_pa_z;
            w_q_n    = ~w_pa_z;
            w_done_n = w_pa_z;
          end else if (r_state == RUN_A && w_last) begin
            w_go_idle = 1'b1;
            w_q_n     = 1'b0;
            w_done_n  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    unique case (1'b1)
      w_st_a: begin
        w_state_n = RUN_A;
        w_per_n   = period_a;
        w_count_n = '0;
        w_presc_n = '0;
      end
      w_st_b: begin
        w_state_n = RUN_B;
        w_per_n   = period_b;
        w_count_n = '0;
        w_presc_n = '0;
      end
      w_go_idle: begin
        w_state_n = IDLE;
        w_count_n = '0;
        w_presc_n = '0;
      end
      w_go_hold: begin
        w_state_n = HOLD;
        w_count_n = '0;
        w_presc_n = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mode       <= '0;
      r_q          <= 1'b0;
      r_done       <= 1'b0;
      r_count      <= '0;
      r_per        <= '0;
      r_presc      <= '0;
      r_trig_prev  <= 1'b0;
      r_clear_prev <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_mode       <= w_mode_n;
      r_q          <= w_q_n;
      r_done       <= w_done_n;
      r_count      <= w_count_n;
      r_per        <= w_per_n;
      r_presc      <= w_presc_n;
      r_trig_prev  <= trig;
      r_clear_prev <= clear;
    end
  end

  assign q       = r_q;
  assign enabled = (r_state != IDLE);
  assign count   = r_count;
  assign done    = r_done;

endmodule
